// File: rtl/regset_arbiter.sv
// regset_arbiter: two-port arbiter and access sequencer for the 8-entry register set.
// Requesters A and B each issue single reads or writes. One requester is granted
// at a time. Each access takes one Enable cycle, and completion is signalled with
// a one-cycle Ack. All outputs come straight from flops.
module regset_arbiter #(
    parameter int N          = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         ReqA,
    input  logic         RwA,
    input  logic [2:0]   AddrA,
    input  logic [N-1:0] DataA,
    output logic         AckA,
    output logic [N-1:0] RdataA,
    input  logic         ReqB,
    input  logic         RwB,
    input  logic [2:0]   AddrB,
    input  logic [N-1:0] DataB,
    output logic         AckB,
    output logic [N-1:0] RdataB,
    output logic         RS_Enable,
    output logic         RS_RW,
    output logic [2:0]   RS_Address,
    output logic [N-1:0] RS_Data_in,
    input  logic [N-1:0] RS_Data_out,
    output logic         Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       r_state, w_nextState;
    logic         r_lastGrantB, w_lastGrantB;
    logic         r_winnerB, w_winnerB;
    logic         r_rsEnable, w_rsEnable;
    logic         r_rsRw, w_rsRw;
    logic [2:0]   r_rsAddress, w_rsAddress;
    logic [N-1:0] r_rsDataIn, w_rsDataIn;
    logic         r_ackA, w_ackA;
    logic         r_ackB, w_ackB;
    logic [N-1:0] r_rdataA, w_rdataA;
    logic [N-1:0] r_rdataB, w_rdataB;
    logic         r_busy, w_busy;
    logic         w_reqAny;
    logic         w_pickA;

    // Decide who would win if a grant were made this cycle; on a tie, round-robin
    // favours the requester that did not win last time.
    always_comb begin
        w_reqAny = ReqA | ReqB;
        if (ReqA && ReqB) begin
            w_pickA = FIXED_PRIO ? 1'b1 : r_lastGrantB;
        end else begin
            w_pickA = ReqA;
        end
    end

    // State register plus every registered output; reset aborts any transaction in flight.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_state      <= IDLE;
            r_lastGrantB <= 1'b1;
            r_winnerB    <= 1'b0;
            r_rsEnable   <= 1'b0;
            r_rsRw       <= 1'b0;
            r_rsAddress  <= '0;
            r_rsDataIn   <= '0;
            r_ackA       <= 1'b0;
            r_ackB       <= 1'b0;
            r_rdataA     <= '0;
            r_rdataB     <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_lastGrantB <= w_lastGrantB;
            r_winnerB    <= w_winnerB;
            r_rsEnable   <= w_rsEnable;
            r_rsRw       <= w_rsRw;
            r_rsAddress  <= w_rsAddress;
            r_rsDataIn   <= w_rsDataIn;
            r_ackA       <= w_ackA;
            r_ackB       <= w_ackB;
            r_rdataA     <= w_rdataA;
            r_rdataB     <= w_rdataB;
            r_busy       <= w_busy;
        end
    end

    // Next-state logic: IDLE waits for a request; ACCESS and DONE each last one cycle.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (w_reqAny) w_nextState = ACCESS;
            ACCESS:  w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Next values of the registered outputs. The command is latched only at grant,
    // so later changes on the requester's fields cannot disturb the access.
    always_comb begin
        w_lastGrantB = r_lastGrantB;
        w_winnerB    = r_winnerB;
        w_rsEnable   = r_rsEnable;
        w_rsRw       = r_rsRw;
        w_rsAddress  = r_rsAddress;
        w_rsDataIn   = r_rsDataIn;
        w_ackA       = r_ackA;
        w_ackB       = r_ackB;
        w_rdataA     = r_rdataA;
        w_rdataB     = r_rdataB;
        w_busy       = r_busy;
        unique case (r_state)
            IDLE: begin
                if (w_reqAny) begin
                    w_winnerB   = ~w_pickA;
                    w_rsEnable  = 1'b1;
                    w_rsRw      = w_pickA ? RwA : RwB;
                    w_rsAddress = w_pickA ? AddrA : AddrB;
                    w_rsDataIn  = w_pickA ? DataA : DataB;
                    w_busy      = 1'b1;
                end
            end
            ACCESS: begin
                w_rsEnable   = 1'b0;
                w_rsRw       = 1'b0;
                w_rsAddress  = '0;
                w_rsDataIn   = '0;
                if (!r_rsRw) begin
                    if (r_winnerB) w_rdataB = RS_Data_out;
                    else           w_rdataA = RS_Data_out;
                end
                w_ackA       = ~r_winnerB;
                w_ackB       = r_winnerB;
                w_lastGrantB = r_winnerB;
            end
            DONE: begin
                w_ackA = 1'b0;
                w_ackB = 1'b0;
                w_busy = 1'b0;
            end
            default: begin
                w_rsEnable = 1'b0;
                w_ackA     = 1'b0;
                w_ackB     = 1'b0;
                w_busy     = 1'b0;
            end
        endcase
    end

    assign AckA       = r_ackA;
    assign AckB       = r_ackB;
    assign RdataA     = r_rdataA;
    assign RdataB     = r_rdataB;
    assign RS_Enable  = r_rsEnable;
    assign RS_RW      = r_rsRw;
    assign RS_Address = r_rsAddress;
    assign RS_Data_in = r_rsDataIn;
    assign Busy       = r_busy;

endmodule
